// File: rtl/ram_rd_arbiter.sv
// ram_rd_arbiter: two-master round-robin arbiter for the RAM read channel (AR + R).
// m0 is the icache and m1 is the dcache. One master is granted per burst, and the
// grant is held until the beat carrying rlast. The arbiter then spends one IDLE
// cycle and arbitrates again.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   m0_/m1_ar{addr,len,valid}    master address requests;   m0_/m1_arready (comb)
//   m0_/m1_r{data,valid,last}    read data to the masters (comb); m0_/m1_rready
//   ram_ar{addr,len,valid}       registered address to the RAM; ram_arready
//   ram_r{data,valid,last}       read data from the RAM;  ram_rready (comb)
//   grant                        current owner (0=m0, 1=m1), meaningful while busy
//   busy                         high in the ADDR and DATA states
module ram_rd_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] m0_araddr,
  input  logic [LWIDTH-1:0] m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic              m0_rlast,
  input  logic [AWIDTH-1:0] m1_araddr,
  input  logic [LWIDTH-1:0] m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic              m1_rlast,
  output logic [AWIDTH-1:0] ram_araddr,
  output logic [LWIDTH-1:0] ram_arlen,
  output logic              ram_arvalid,
  input  logic              ram_arready,
  input  logic [DWIDTH-1:0] ram_rdata,
  input  logic              ram_rvalid,
  output logic              ram_rready,
  input  logic              ram_rlast,
  output logic              grant,
  output logic              busy
);

  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t           state;
  logic             last;   // owner of the most recently completed burst
  logic [NUM_M-1:0] req;
  logic             win;

  assign req = {m1_arvalid, m0_arvalid};

  // Single requester wins outright; on a tie the master not served last wins.
  always_comb begin
    win = req[1];
    if (&req) win = ~last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_araddr  <= '0;
      ram_arlen   <= '0;
      ram_arvalid <= 1'b0;
      grant       <= 1'b0;
      last        <= 1'b1;  // so m0 wins the first tie after reset
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ram_araddr  <= win ? m1_araddr : m0_araddr;
            ram_arlen   <= win ? m1_arlen  : m0_arlen;
            ram_arvalid <= 1'b1;
            grant       <= win;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (ram_arready) begin
            ram_arvalid <= 1'b0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (ram_rvalid && ram_rready && ram_rlast) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: begin
          ram_arvalid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  logic             in_addr, in_data;
  logic [NUM_M-1:0] arready_v, rvalid_v, rlast_v, rready_v;

  assign in_addr  = (state == ADDR);
  assign in_data  = (state == DATA);
  assign busy     = in_addr | in_data;
  assign rready_v = {m1_rready, m0_rready};

  // Only the granted master sees the handshake and beat strobes. Read data is
  // broadcast to both masters.
  for (genvar g = 0; g < NUM_M; g++) begin : g_mst
    logic sel;
    assign sel          = (grant == 1'(g));
    assign arready_v[g] = in_addr & sel & ram_arready;
    assign rvalid_v[g]  = in_data & sel & ram_rvalid;
    assign rlast_v[g]   = in_data & sel & ram_rlast;
  end

  assign ram_rready = in_data & rready_v[grant];

  assign m0_arready = arready_v[0];
  assign m1_arready = arready_v[1];
  assign m0_rvalid  = rvalid_v[0];
  assign m1_rvalid  = rvalid_v[1];
  assign m0_rlast   = rlast_v[0];
  assign m1_rlast   = rlast_v[1];
  assign m0_rdata   = ram_rdata;
  assign m1_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Randomised bench for ram_rd_arbiter. The bench contains two master models
// that keep queues of pending reads and a RAM model with random accept and beat
// timing. A transaction-level reference predicts the owner of each burst,
// expects that owner's queued request to appear on the RAM address channel, and
// scores every delivered beat against the data the RAM model generated.
module tb_ram_rd_arbiter;
  localparam int AW = 32, DW = 32, LW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
  logic [LW-1:0] m0_arlen = '0, m1_arlen = '0;
  logic          m0_arvalid = 1'b0, m1_arvalid = 1'b0, m0_rready = 1'b0, m1_rready = 1'b0;
  logic          m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_araddr;
  logic [LW-1:0] ram_arlen;
  logic          ram_arvalid, ram_rready, grant, busy;
  logic          ram_arready = 1'b0, ram_rvalid = 1'b0, ram_rlast = 1'b0;
  logic [DW-1:0] ram_rdata = '0;

  ram_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast),
    .ram_araddr(ram_araddr), .ram_arlen(ram_arlen), .ram_arvalid(ram_arvalid),
    .ram_arready(ram_arready), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .ram_rready(ram_rready), .ram_rlast(ram_rlast), .grant(grant), .busy(busy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len;} req_t;

  // Reference state, all at transaction level.
  req_t          mq[2][$];        // pending reads per master, head = presented request
  int            last_srv = 1;    // owner of the last finished burst
  bit            in_burst = 0;    // a grant is outstanding
  bit            ar_done  = 0;    // its AR handshake has happened (data phase)
  int            owner = 0;
  req_t          cur;
  logic [DW-1:0] bdata[4];
  int            nbeats = 0, ram_idx = 0, mst_idx = 0;
  bit            rv_hold = 0, did_rst = 0;

  // Values present just before the most recent rising edge.
  logic       s_rst = 1'b1;
  logic [1:0] s_arv, s_arr, s_mrv, s_mrr, s_mrl;
  logic       s_rarv, s_rarr, s_rrv, s_rrr;
  logic [DW-1:0] s_rdata[2];

  function automatic req_t rnd_req();
    req_t r;
    r.addr = {$urandom_range(0, 32'hFFFF), 2'b00};
    r.len  = LW'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    s_arv = '0; s_arr = '0; s_mrv = '0; s_mrr = '0; s_mrl = '0;
    s_rarv = 0; s_rarr = 0; s_rrv = 0; s_rrr = 0;
    s_rdata[0] = '0; s_rdata[1] = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (s_rst) begin
        // After a reset edge everything is back to idle, with the RAM side also cleared.
        chk("rst_arvalid", ram_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_araddr", ram_araddr, 0);
        chk("rst_arlen", ram_arlen, 0);
        mq[0].delete(); mq[1].delete();
        in_burst = 0; ar_done = 0; last_srv = 1; rv_hold = 0;
        // Both masters request together after reset: the tie must go to m0.
        mq[0].push_back(rnd_req()); mq[1].push_back(rnd_req());
      end else begin
        bit ram_beat, mst_beat, ram_act;
        ram_act  = ar_done && (ram_idx < nbeats);
        ram_beat = s_rrv && s_rrr;
        mst_beat = 1'b0;
        for (int i = 0; i < 2; i++)
          if (s_arv[i] && s_arr[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (s_rarv && s_rarr) begin
          ar_done = 1; nbeats = int'(cur.len) + 1; ram_idx = 0; mst_idx = 0;
          for (int b = 0; b < 4; b++) bdata[b] = $urandom;
        end else if (ram_beat) begin
          if (!ram_act) chk("rready_outside_data", 1, 0);
          else begin ram_idx++; rv_hold = 0; end
        end
        for (int i = 0; i < 2; i++) begin
          if (s_mrv[i] && s_mrr[i]) begin
            mst_beat = 1'b1;
            chk("beat_owner", i, owner);
            if (mst_idx < nbeats) begin
              chk("beat_data", s_rdata[i], bdata[mst_idx]);
              chk("beat_last", s_mrl[i], (mst_idx == nbeats - 1));
            end else chk("beat_extra", mst_idx, nbeats - 1);
            mst_idx++;
            if (s_mrl[i]) begin
              last_srv = i; in_burst = 0; ar_done = 0;
              // A re-grant needs one IDLE cycle first.
              chk("gap_busy", busy, 0);
              chk("gap_arvalid", ram_arvalid, 0);
            end
          end
        end
        chk("beat_sync", mst_beat, ram_beat && ram_act);
        if (ram_arvalid && !in_burst) begin
          if (!s_arv[0] && !s_arv[1]) chk("spurious_ar", 1, 0);
          else begin
            owner = (s_arv[0] && s_arv[1]) ? 1 - last_srv : (s_arv[1] ? 1 : 0);
            cur = mq[owner][0];
            in_burst = 1; ar_done = 0;
            chk("grant", grant, owner);
            chk("ar_addr", ram_araddr, cur.addr);
            chk("ar_len", ram_arlen, cur.len);
          end
        end
      end
      if (in_burst && !ar_done) begin
        chk("ar_hold", ram_arvalid, 1);
        chk("ar_stable", ram_araddr, cur.addr);
      end
      if (in_burst && ar_done) chk("ar_drop", ram_arvalid, 0);
      chk("busy", busy, in_burst);
      if (in_burst) chk("grant_hold", grant, owner);

      // Drive the next cycle. There is an initial reset, and one more reset mid-data-phase.
      rst = (cyc < 3);
      if (cyc >= 3000 && !did_rst && in_burst && ar_done) begin rst = 1'b1; did_rst = 1; end
      for (int i = 0; i < 2; i++) begin
        int pct;
        case ((cyc / 500) % 3)
          0:       pct = 60;
          1:       pct = (i == 0) ? 5 : 60;
          default: pct = (i == 1) ? 5 : 60;
        endcase
        if (mq[i].size() < 3 && $urandom_range(0, 99) < pct) mq[i].push_back(rnd_req());
      end
      m0_arvalid = (mq[0].size() > 0);
      m1_arvalid = (mq[1].size() > 0);
      if (m0_arvalid) begin m0_araddr = mq[0][0].addr; m0_arlen = mq[0][0].len; end
      if (m1_arvalid) begin m1_araddr = mq[1][0].addr; m1_arlen = mq[1][0].len; end
      m0_rready   = ($urandom_range(0, 3) != 0);
      m1_rready   = ($urandom_range(0, 3) != 0);
      ram_arready = ($urandom_range(0, 2) == 0);
      if (ar_done && ram_idx < nbeats) begin
        // The RAM keeps rvalid asserted until the beat is taken.
        if (!rv_hold) rv_hold = ($urandom_range(0, 2) != 0);
        ram_rvalid = rv_hold;
        ram_rdata  = bdata[ram_idx];
        ram_rlast  = (ram_idx == nbeats - 1);
      end else begin
        // Stray read-channel activity outside a data phase must be ignored.
        ram_rvalid = ($urandom_range(0, 3) == 0);
        ram_rdata  = $urandom;
        ram_rlast  = 1'($urandom_range(0, 1));
      end

      #1;
      for (int i = 0; i < 2; i++) begin
        bit sel, dph;
        sel = in_burst && (owner == i);
        dph = in_burst && ar_done;
        chk("arready", (i == 0) ? m0_arready : m1_arready, sel && !ar_done && ram_arready);
        chk("rvalid", (i == 0) ? m0_rvalid : m1_rvalid, sel && dph && ram_rvalid);
        chk("rlast", (i == 0) ? m0_rlast : m1_rlast, sel && dph && ram_rlast);
        chk("rdata", (i == 0) ? m0_rdata : m1_rdata, ram_rdata);
      end
      chk("ram_rready", ram_rready,
          (in_burst && ar_done) ? ((owner == 0) ? m0_rready : m1_rready) : 1'b0);

      s_rst = rst;
      s_arv = {m1_arvalid, m0_arvalid};
      s_arr = {m1_arready, m0_arready};
      s_mrv = {m1_rvalid, m0_rvalid};
      s_mrr = {m1_rready, m0_rready};
      s_mrl = {m1_rlast, m0_rlast};
      s_rdata[0] = m0_rdata; s_rdata[1] = m1_rdata;
      s_rarv = ram_arvalid; s_rarr = ram_arready;
      s_rrv = ram_rvalid;   s_rrr = ram_rready;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
